// File: rtl/xbus_cfg_fetch_if.sv
// Xbus initiator-to-slave signal bundle: request strobe, address/data and the
// slave's single-cycle acknowledge with read data.
`timescale 1ns/1ps
interface xbus_cfg_fetch_if;
  logic        xbs_select;
  logic [31:0] xbs_addr;
  logic [31:0] xbs_data;
  logic        xbs_rnw;
  logic [3:0]  xbs_be;
  logic        sl_ack;
  logic [31:0] sl_data;

  modport master (
    output xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    input  sl_ack, sl_data
  );

  modport slave (
    input  xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    output sl_ack, sl_data
  );
endinterface

// File: rtl/xbus_cfg_fetch.sv
// Read-only xbus master: fetches word_count configuration words starting at
// base_addr, one transaction at a time, into a small FIFO for a streaming consumer.
`timescale 1ns/1ps
module xbus_cfg_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [15:0]           word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  xbus_cfg_fetch_if.master      xbs,
  output logic [31:0]           cfg_data_o,
  output logic                  cfg_valid_o,
  input  logic                  cfg_ready_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [15:0]       rem_q;
  logic [TO_W-1:0]   tcnt_q;
  logic              select_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic push;
  logic pop;
  logic flush;
  logic space_ok;

  assign push     = (state_q == S_WAIT) && xbs.sl_ack;
  assign pop      = cfg_valid_o && cfg_ready_i;
  assign flush    = (state_q == S_ERR);
  // Nothing is outstanding in REQ, so one free slot covers the word about to be requested.
  assign space_ok = (count_q < CNT_FULL);

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= xbs.sl_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      tcnt_q   <= '0;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      select_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= base_addr_i;
            rem_q   <= word_count_i;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            state_q <= (word_count_i == 16'd0) ? S_DRAIN : S_REQ;
          end
        end
        S_REQ: begin
          if (space_ok) begin
            select_q <= 1'b1;
            tcnt_q   <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (xbs.sl_ack) begin
            addr_q  <= addr_q + 32'd1;
            rem_q   <= rem_q - 16'd1;
            state_q <= (rem_q == 16'd1) ? S_DRAIN : S_REQ;
          end else if (tcnt_q == TO_LAST) begin
            state_q <= S_ERR;
          end else begin
            tcnt_q <= tcnt_q + TO_ONE;
          end
        end
        S_DRAIN: begin
          if (count_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          error_q <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign xbs.xbs_select = select_q;
  assign xbs.xbs_addr   = addr_q;
  assign xbs.xbs_data   = 32'd0;
  assign xbs.xbs_rnw    = 1'b1;
  assign xbs.xbs_be     = 4'hF;
  assign cfg_data_o     = fifo_mem[rd_ptr_q];
  assign cfg_valid_o    = (count_q != '0);

endmodule

// File: tb/tb_xbus_cfg_fetch.sv
// Directed bench for xbus_cfg_fetch: a one-cycle-latency memory model on the
// slave side, a negedge monitor logging requests, pops and done pulses.
`timescale 1ns/1ps
module tb_xbus_cfg_fetch;
  localparam int MEMDELAY = 1;
  localparam int TIMEOUT  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] word_count_i = '0;
  logic        busy_o, done_o, error_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_ready_i = 1'b0;
  logic        ack_en = 1'b1;

  xbus_cfg_fetch_if bus();

  xbus_cfg_fetch #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .xbs          (bus),
    .cfg_data_o   (cfg_data_o),
    .cfg_valid_o  (cfg_valid_o),
    .cfg_ready_i  (cfg_ready_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory contents: word at address a holds a + 0x90 (so 0x10..0x13 -> A0..A3).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h90;
  endfunction

  // Monitor and slave model state, written only by the negedge process.
  int          cyc = 0;
  logic [31:0] sel_addrs[$];
  int          sel_cycs[$];
  logic [31:0] popped[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          prev_sel = 0, prev_done = 0;
  bit          dbl_sel = 0, dbl_done = 0, busy_done = 0, outst_err = 0;
  bit          pending = 0;
  int          dly = 0;
  logic [31:0] paddr = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pending     = 0;
      prev_sel    = 0;
      prev_done   = 0;
      bus.sl_ack  = 1'b0;
      bus.sl_data = '0;
    end else begin
      if (bus.xbs_select) begin
        if (prev_sel) dbl_sel = 1;
        if (pending)  outst_err = 1;
        sel_addrs.push_back(bus.xbs_addr);
        sel_cycs.push_back(cyc);
      end
      prev_sel = bus.xbs_select;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_done) dbl_done = 1;
        if (busy_o)    busy_done = 1;
      end
      prev_done = done_o;
      if (cfg_valid_o && cfg_ready_i) popped.push_back(cfg_data_o);
      bus.sl_ack = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          bus.sl_ack  = 1'b1;
          bus.sl_data = mem_word(paddr);
          pending     = 0;
        end else begin
          dly--;
        end
      end
      if (bus.xbs_select && ack_en) begin
        pending = 1;
        dly     = MEMDELAY - 1;
        paddr   = bus.xbs_addr;
      end
    end
  end

  // Per-job baselines, captured when the job is launched.
  int t0 = 0, sel_base = 0, pop_base = 0, done_base = 0;

  task automatic start_job(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    sel_base     = sel_addrs.size();
    pop_base     = popped.size();
    done_base    = done_cnt;
    base_addr_i  = b;
    word_count_i = n;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    t0      = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt > done_base) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, error_o, bus.xbs_select, bus.xbs_rnw, bus.xbs_be, cfg_valid_o}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/done/err/sel/rnw/be/valid=%b%b%b%b%b%h%b want 00001f0",
               busy_o, done_o, error_o, bus.xbs_select, bus.xbs_rnw, bus.xbs_be, cfg_valid_o);
    end
    checks++;
    if (bus.xbs_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 00000000", bus.xbs_addr);
    end
    checks++;
    if (bus.xbs_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", bus.xbs_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] exp_a [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    cfg_ready_i = 1'b1;
    start_job(32'h10, 16'd4);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got no done want done within 200 cycles"); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sel_addrs.size() - sel_base !== 4) begin
      errors++; $display("FAIL basic_nreq: got %0d want 4", sel_addrs.size() - sel_base);
    end
    for (int i = 0; i < 4 && sel_base + i < sel_addrs.size(); i++) begin
      checks++;
      if (sel_addrs[sel_base + i] !== exp_a[i]) begin
        errors++; $display("FAIL basic_addr%0d: got %h want %h", i, sel_addrs[sel_base + i], exp_a[i]);
      end
    end
    checks++;
    if (sel_cycs.size() > sel_base && sel_cycs[sel_base] - t0 !== 2) begin
      errors++; $display("FAIL basic_first_req: got %0d cycles want 2", sel_cycs[sel_base] - t0);
    end
    for (int i = 1; i < 4 && sel_base + i < sel_cycs.size(); i++) begin
      checks++;
      if (sel_cycs[sel_base + i] - sel_cycs[sel_base + i - 1] !== 3) begin
        errors++; $display("FAIL basic_spacing%0d: got %0d want 3", i,
                           sel_cycs[sel_base + i] - sel_cycs[sel_base + i - 1]);
      end
    end
    checks++;
    if (popped.size() - pop_base !== 4) begin
      errors++; $display("FAIL basic_npop: got %0d want 4", popped.size() - pop_base);
    end
    for (int i = 0; i < 4 && pop_base + i < popped.size(); i++) begin
      checks++;
      if (popped[pop_base + i] !== exp_d[i]) begin
        errors++; $display("FAIL basic_data%0d: got %h want %h", i, popped[pop_base + i], exp_d[i]);
      end
    end
    checks++;
    if ({done_cnt - done_base, error_o, busy_o} !== {32'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_end: got done=%0d err=%b busy=%b want 1 0 0",
                         done_cnt - done_base, error_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    cfg_ready_i = 1'b0;
    start_job(32'h20, 16'd8);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (sel_addrs.size() - sel_base !== 4) begin
      errors++; $display("FAIL bp_stall_nreq: got %0d want 4", sel_addrs.size() - sel_base);
    end
    checks++;
    if ({cfg_valid_o, busy_o, bus.xbs_select} !== 3'b110) begin
      errors++; $display("FAIL bp_stall_state: got valid/busy/sel=%b%b%b want 110",
                         cfg_valid_o, busy_o, bus.xbs_select);
    end
    cfg_ready_i = 1'b1;
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: got no done want done within 300 cycles"); end
    checks++;
    if (sel_addrs.size() - sel_base !== 8) begin
      errors++; $display("FAIL bp_nreq: got %0d want 8", sel_addrs.size() - sel_base);
    end
    checks++;
    if (popped.size() - pop_base !== 8) begin
      errors++; $display("FAIL bp_npop: got %0d want 8", popped.size() - pop_base);
    end
    for (int i = 0; i < 8 && pop_base + i < popped.size(); i++) begin
      checks++;
      if (popped[pop_base + i] !== 32'hB0 + 32'(i)) begin
        errors++; $display("FAIL bp_data%0d: got %h want %h", i, popped[pop_base + i], 32'hB0 + 32'(i));
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    cfg_ready_i = 1'b1;
    ack_en      = 1'b0;
    start_job(32'h40, 16'd1);
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_done: got no done want done within 100 cycles"); end
    checks++;
    if ({error_o, cfg_valid_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL to_state: got err/valid/busy=%b%b%b want 100", error_o, cfg_valid_o, busy_o);
    end
    checks++;
    if (done_cyc - t0 < TIMEOUT || done_cyc - t0 > TIMEOUT + 6) begin
      errors++; $display("FAIL to_latency: got %0d cycles want %0d..%0d", done_cyc - t0, TIMEOUT, TIMEOUT + 6);
    end
    checks++;
    if (sel_addrs.size() - sel_base !== 1) begin
      errors++; $display("FAIL to_nreq: got %0d want 1", sel_addrs.size() - sel_base);
    end
    // Timeout with a word already buffered: the FIFO must be flushed.
    ack_en      = 1'b1;
    cfg_ready_i = 1'b0;
    start_job(32'h48, 16'd3);
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", error_o); end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (cfg_valid_o) ok = 1;
    end
    ack_en = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL to_first_word: got no cfg_valid want cfg_valid within 20 cycles"); end
    wait_done(150, ok);
    checks++;
    if (!ok || {error_o, cfg_valid_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL to_flush: got done=%b err/valid/busy=%b%b%b want 1 100",
                         ok, error_o, cfg_valid_o, busy_o);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_zero_count();
    bit ok;
    cfg_ready_i = 1'b1;
    start_job(32'h50, 16'd0);
    wait_done(5, ok);
    checks++;
    if (!ok || done_cyc - t0 > 2) begin
      errors++; $display("FAIL zero_done: got done=%b after %0d cycles want done within 2", ok, done_cyc - t0);
    end
    checks++;
    if (sel_addrs.size() - sel_base !== 0) begin
      errors++; $display("FAIL zero_nreq: got %0d want 0", sel_addrs.size() - sel_base);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    cfg_ready_i = 1'b1;
    start_job(32'h60, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    base_addr_i  = 32'h70;
    word_count_i = 16'd1;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(200, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || sel_addrs.size() - sel_base !== 4 || popped.size() - pop_base !== 4) begin
      errors++; $display("FAIL restart_counts: got done=%b req=%0d pop=%0d want 1 4 4",
                         ok, sel_addrs.size() - sel_base, popped.size() - pop_base);
    end
    for (int i = 0; i < 4 && pop_base + i < popped.size() && sel_base + i < sel_addrs.size(); i++) begin
      checks++;
      if ({sel_addrs[sel_base + i], popped[pop_base + i]} !== {32'h60 + 32'(i), 32'hF0 + 32'(i)}) begin
        errors++; $display("FAIL restart_word%0d: got addr %h data %h want %h %h", i,
                           sel_addrs[sel_base + i], popped[pop_base + i], 32'h60 + 32'(i), 32'hF0 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_midjob();
    bit ok;
    int d_before;
    cfg_ready_i = 1'b0;
    ack_en      = 1'b1;
    start_job(32'h80, 16'd4);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (cfg_valid_o) ok = 1;
    end
    ack_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!ok || {busy_o, cfg_valid_o} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got word=%b busy/valid=%b%b want 1 11", ok, busy_o, cfg_valid_o);
    end
    d_before = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, error_o, bus.xbs_select, bus.xbs_addr, cfg_valid_o}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL rst_async: got busy/done/err/sel=%b%b%b%b addr=%h valid=%b want 0000 00000000 0",
                         busy_o, done_o, error_o, bus.xbs_select, bus.xbs_addr, cfg_valid_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d_before) begin
      errors++; $display("FAIL rst_no_done: got %0d done pulses want 0", done_cnt - d_before);
    end
    cfg_ready_i = 1'b1;
    start_job(32'h10, 16'd4);
    wait_done(200, ok);
    checks++;
    if (!ok || popped.size() - pop_base !== 4) begin
      errors++; $display("FAIL rst_fresh: got done=%b pop=%0d want 1 4", ok, popped.size() - pop_base);
    end
    for (int i = 0; i < 4 && pop_base + i < popped.size(); i++) begin
      checks++;
      if (popped[pop_base + i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL rst_fresh_data%0d: got %h want %h", i, popped[pop_base + i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [31:0] exp_a [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] exp_d [3] = '{32'h8E, 32'h8F, 32'h90};
    cfg_ready_i = 1'b1;
    start_job(32'hFFFF_FFFE, 16'd3);
    wait_done(200, ok);
    checks++;
    if (!ok || sel_addrs.size() - sel_base !== 3 || error_o !== 1'b0) begin
      errors++; $display("FAIL wrap_end: got done=%b req=%0d err=%b want 1 3 0",
                         ok, sel_addrs.size() - sel_base, error_o);
    end
    for (int i = 0; i < 3 && sel_base + i < sel_addrs.size() && pop_base + i < popped.size(); i++) begin
      checks++;
      if ({sel_addrs[sel_base + i], popped[pop_base + i]} !== {exp_a[i], exp_d[i]}) begin
        errors++; $display("FAIL wrap_word%0d: got addr %h data %h want %h %h", i,
                           sel_addrs[sel_base + i], popped[pop_base + i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_count();
    test_restart_ignored();
    test_reset_midjob();
    test_addr_wrap();
    checks++;
    if ({dbl_sel, outst_err, dbl_done, busy_done} !== 4'b0000) begin
      errors++; $display("FAIL protocol: got dbl_sel/outstanding/dbl_done/busy_at_done=%b%b%b%b want 0000",
                         dbl_sel, outst_err, dbl_done, busy_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished by 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/xbus_cfg_fetch.md
# xbus_cfg_fetch

Xbus master that fetches a block of 32-bit configuration words from external configuration memory and streams them to a downstream consumer, such as the ICAP/reconfiguration port model. It sits on the initiator side of the xbus, driving the memory controller's slave interface. It issues single-word read transactions, one outstanding at a time. Returned words are buffered in a small FIFO, so memory latency and consumer back-pressure are decoupled.

## Interface
- FIFO_DEPTH, 4: output buffer depth in words (power of 2, ≥2).
- TIMEOUT, 64: max cycles to wait for `sl_ack` before aborting.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a fetch when idle.
- base_addr  input  32  first word address (word-addressed, not byte).
- word_count  input  16  number of words to fetch.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at end of job (success or error).
- error  output  1  sticky timeout flag; cleared by the next accepted start.
- xbs_select  output  1  request strobe to slave.
- xbs_addr  output  32  word address.
- xbs_data  output  32  write data; always 0 (read-only master).
- xbs_rnw  output  1  always 1 while requesting.
- xbs_be  output  4  always 4'hF.
- sl_ack  input  1  slave acknowledge; one-cycle pulse.
- sl_data  input  32  read data; valid in the cycle `sl_ack`=1.
- cfg_data  output  32  FIFO head word.
- cfg_valid  output  1  FIFO not empty.
- cfg_ready  input  1  consumer accepts head when `cfg_valid` and `cfg_ready` are both high.

## Operation
- Reset values: `busy`=0, `done`=0, `error`=0, `xbs_select`=0, `xbs_addr`=0, `xbs_data`=0, `xbs_rnw`=1, `xbs_be`=4'hF, `cfg_valid`=0. The FIFO is emptied and the FSM is in IDLE.
- **IDLE**:
  - `start` latches `base_addr` into the address counter and `word_count` into the remaining counter. It sets `busy`, clears `error`, and the FSM goes to REQ.
  - If `word_count`=0, the FSM goes directly to DRAIN.
  - `start` while not in IDLE is ignored.
- **REQ**:
  - Requires free FIFO slots > 0, counting the slot reserved for the in-flight word.
  - When that holds, `xbs_select` is driven high for exactly one cycle with `xbs_addr` = address counter, and the FSM goes to WAIT.
  - Otherwise the FSM stays in REQ with `xbs_select`=0.
- **WAIT**:
  - `xbs_addr` is held stable and `xbs_select` stays 0.
  - On `sl_ack`=1: `sl_data` is pushed to the FIFO, the address increments by 1, and remaining decrements by 1. The FSM goes to REQ if remaining is still >0, else to DRAIN.
  - A timeout counter starts at 0 on entry. If it reaches TIMEOUT-1 without an ack, the FSM goes to ERR.
- **DRAIN**: waits until the FIFO is empty, then pulses `done`, clears `busy`, and returns to IDLE.
- **ERR**: sets `error`, flushes the FIFO (`cfg_valid`→0), pulses `done`, clears `busy`, and returns to IDLE. A late `sl_ack` in IDLE is ignored.
- **FIFO**:
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - A push when full cannot occur, because of the slot reservation.
  - Pointers wrap modulo FIFO_DEPTH.
- **Address counter**: 32-bit and wraps 32'hFFFFFFFF→0 with no error.
- Asynchronous `rst` mid-job aborts immediately to the reset values; no `done` is issued.

## Timing
- Start accepted at edge E0: `busy`=1 and state=REQ after E0. `xbs_select`=1 in the cycle after E0 (registered) if space is available.
- `xbs_select` is never high on two consecutive cycles, and never while a transaction is outstanding.
- Ack sampled at edge Ea: the word is visible as `cfg_valid`=1 after Ea when the FIFO was empty. The next `xbs_select` is asserted in the cycle after Ea, giving a minimum 2-cycle request spacing plus slave latency.
- `cfg_data` and `cfg_valid` come from registers and FIFO storage; there is no combinational path from `sl_data` or `cfg_ready`.
- `done` is high for exactly 1 cycle. `busy` falls in the same cycle `done` rises.

## Test plan
- Reset, then `start` with base_addr=0x10, word_count=4 and `cfg_ready`=1 against the memory model (MEMDELAY=1) preloaded with mem[0x10..0x13]=A0..A3 → four requests at 0x10..0x13, each with `xbs_select` one cycle wide; `cfg_data` sequence A0,A1,A2,A3; one `done` pulse; `error`=0.
- `cfg_ready`=0, word_count=8, FIFO_DEPTH=4 → exactly 4 requests issued, then `xbs_select` stays 0. Releasing `cfg_ready` resumes fetching, and all 8 words arrive in order with none lost or duplicated.
- Slave never acks (select unconnected) → after 64 cycles in WAIT: `error`=1, `done` pulse, `cfg_valid`=0, `busy`=0. The next `start` clears `error`.
- `start` with word_count=0 → no `xbs_select`; `done` pulses within 2 cycles.
- `start` re-pulsed mid-job and `rst` asserted mid-WAIT → the re-pulse has no effect. The reset forces every output to its reset value within the same cycle. A fresh job after reset completes correctly.
- base_addr=0xFFFFFFFE, word_count=3 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
